// File: rtl/datamem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port count,
// counter widths and a saturating-increment helper.
// Width macros WORD_SIZE / BLOCK_SIZE normally come from the surrounding
// codebase; fallbacks are provided so the block builds on its own.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif

package datamem_arbiter_pkg;

   localparam int NUM_PORTS = 2;
   localparam int CNT_W     = 4;   // holds MEM_LAT-1 for MEM_LAT in 1..15
   localparam int STAT_W    = 32;

   typedef enum logic [2:0] {
      ARB_IDLE    = 3'd0,
      ARB_ISSUE   = 3'd1,
      ARB_HOLD    = 3'd2,
      ARB_RELEASE = 3'd3,
      ARB_FLUSH   = 3'd4
   } arb_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/datamem_arbiter_rr_pick2.sv
// Two-input round-robin grant: the port named by ptr wins when it is valid,
// otherwise the other port wins if valid. Grant is one-hot or zero.
module datamem_arbiter_rr_pick2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   // Preferred port first, then the alternate.
   always_comb begin
      grant = '0;
      if (valid[ptr]) begin
         grant[ptr] = 1'b1;
      end else if (valid[~ptr]) begin
         grant[~ptr] = 1'b1;
      end
   end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the block data memory.
// One access at a time: IDLE (arbitrate) -> ISSUE (strobe up) -> HOLD
// (MEM_LAT cycles, read captured on the last) -> RELEASE (strobe down,
// response pulse). A halt drains to FLUSH, which is terminal until rst.
// Optional build macro DATAMEM_ARB_STATS_EN adds per-port read/write counters.
//
// Handshake: a request on port i is taken in the cycle where
// req_valid[i] & req_ready[i]; the requester holds its signals stable until
// then. resp_valid[i] is a single-cycle completion pulse with no back-pressure.
module datamem_arbiter
   import datamem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = `WORD_SIZE,
   parameter int BLK_W   = `BLOCK_SIZE,
   parameter int MEM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   input  logic [1:0]           req_we,
   input  logic [2*ADDR_W-1:0]  req_addr,
   input  logic [2*BLK_W-1:0]   req_wdata,
   output logic [1:0]           req_ready,
   output logic [1:0]           resp_valid,
   output logic [2*BLK_W-1:0]   resp_data,
   input  logic                 halt,
   output logic                 halt_done,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_readable,
   output logic                 mem_writable,
   output logic [BLK_W-1:0]     mem_write,
   input  logic [BLK_W-1:0]     mem_out1,
   input  logic [BLK_W-1:0]     mem_out2,
   output logic                 mem_flush,
`ifdef DATAMEM_ARB_STATS_EN
   output logic [2*STAT_W-1:0]  stat_rd,
   output logic [2*STAT_W-1:0]  stat_wr,
`endif
   output logic [2:0]           dbg_state
);

   arb_state_e            state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic                  port_q, port_d;
   logic                  we_q, we_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [BLK_W-1:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*BLK_W-1:0]    resp_data_q, resp_data_d;
   logic [1:0]            grant;

   datamem_arbiter_rr_pick2 u_pick (
      .valid (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   // Next-state, request latching and strobe/handshake outputs.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      port_d       = port_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      resp_data_d  = resp_data_q;
      req_ready    = '0;
      resp_valid   = '0;
      mem_readable = 1'b0;
      mem_writable = 1'b0;
      mem_flush    = 1'b0;
      halt_done    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            // Halt wins over any new request.
            if (halt) begin
               state_d = ARB_FLUSH;
            end else if (grant != 2'b00) begin
               req_ready = grant;
               port_d    = grant[1];
               we_d      = req_we[grant[1]];
               addr_d    = grant[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
               wdata_d   = grant[1] ? req_wdata[2*BLK_W-1:BLK_W] : req_wdata[BLK_W-1:0];
               state_d   = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            mem_readable = ~we_q;
            mem_writable = we_q;
            cnt_d        = CNT_W'(MEM_LAT - 1);
            state_d      = ARB_HOLD;
         end
         ARB_HOLD: begin
            mem_readable = ~we_q;
            mem_writable = we_q;
            if (cnt_q == '0) begin
               if (!we_q) begin
                  resp_data_d = {mem_out1, mem_out2};
               end
               state_d = ARB_RELEASE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ARB_RELEASE: begin
            // Strobes are low here, giving the memory its low phase.
            resp_valid = port_q ? 2'b10 : 2'b01;
            ptr_d      = ~port_q;
            state_d    = halt ? ARB_FLUSH : ARB_IDLE;
         end
         ARB_FLUSH: begin
            mem_flush = 1'b1;
            halt_done = 1'b1;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State and latched-request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         ptr_q       <= 1'b0;
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         port_q      <= port_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_write = wdata_q;
   assign resp_data = resp_data_q;
   assign dbg_state = state_q;

`ifdef DATAMEM_ARB_STATS_EN
   logic [1:0][STAT_W-1:0] stat_rd_q, stat_rd_d;
   logic [1:0][STAT_W-1:0] stat_wr_q, stat_wr_d;

   // Count each completed access against its port and direction.
   always_comb begin
      stat_rd_d = stat_rd_q;
      stat_wr_d = stat_wr_q;
      if (state_q == ARB_RELEASE) begin
         if (we_q) begin
            stat_wr_d[port_q] = sat_inc(stat_wr_q[port_q]);
         end else begin
            stat_rd_d[port_q] = sat_inc(stat_rd_q[port_q]);
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_q <= '0;
         stat_wr_q <= '0;
      end else begin
         stat_rd_q <= stat_rd_d;
         stat_wr_q <= stat_wr_d;
      end
   end

   assign stat_rd = stat_rd_q;
   assign stat_wr = stat_wr_q;
`endif

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: behavioural block memory, per-port drivers,
// a negedge monitor holding a reference memory, a round-robin pointer model
// and an expected-response queue.
module tb_datamem_arbiter;
   import datamem_arbiter_pkg::*;

   localparam int AW      = 16;
   localparam int BW      = 32;
   localparam int MEM_LAT = 1;
   localparam int W       = 2*BW + 2;   // {port, we, resp_data}

   logic            clk;
   logic            rst;
   logic [1:0]      req_valid;
   logic [1:0]      req_we;
   logic [2*AW-1:0] req_addr;
   logic [2*BW-1:0] req_wdata;
   logic [1:0]      req_ready;
   logic [1:0]      resp_valid;
   logic [2*BW-1:0] resp_data;
   logic            halt;
   logic            halt_done;
   logic [AW-1:0]   mem_addr;
   logic            mem_readable;
   logic            mem_writable;
   logic [BW-1:0]   mem_write;
   logic [BW-1:0]   mem_out1;
   logic [BW-1:0]   mem_out2;
   logic            mem_flush;
   logic [2:0]      dbg_state;
`ifdef DATAMEM_ARB_STATS_EN
   logic [63:0]     stat_rd;
   logic [63:0]     stat_wr;
`endif

   datamem_arbiter #(.ADDR_W(AW), .BLK_W(BW), .MEM_LAT(MEM_LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .halt         (halt),
      .halt_done    (halt_done),
      .mem_addr     (mem_addr),
      .mem_readable (mem_readable),
      .mem_writable (mem_writable),
      .mem_write    (mem_write),
      .mem_out1     (mem_out1),
      .mem_out2     (mem_out2),
      .mem_flush    (mem_flush),
`ifdef DATAMEM_ARB_STATS_EN
      .stat_rd      (stat_rd),
      .stat_wr      (stat_wr),
`endif
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   // Preload pattern shared by the memory model and the reference.
   function automatic logic [BW-1:0] init_val(input logic [8:0] a);
      return {7'h55, a, 7'h2a, a};
   endfunction

   // ---------------- behavioural data memory ----------------
   logic [BW-1:0] wr_mem [0:511];
   bit            wr_vld [0:511];
   logic [8:0]    m_i1, m_i2;

   always @(posedge clk) begin
      if (mem_writable) begin
         wr_mem[mem_addr[8:0]] <= mem_write;
         wr_vld[mem_addr[8:0]] <= 1'b1;
      end
   end

   always_comb begin
      m_i1     = mem_addr[8:0];
      m_i2     = mem_addr[8:0] + 9'd1;
      mem_out1 = wr_vld[m_i1] ? wr_mem[m_i1] : init_val(m_i1);
      mem_out2 = wr_vld[m_i2] ? wr_mem[m_i2] : init_val(m_i2);
   end

   // ---------------- scoreboard / monitor ----------------
   logic [W-1:0]    exp_q[$];
   int              acc_q[$];
   logic [BW-1:0]   ref_mem [0:511];
   bit              ref_vld [0:511];
   logic [2*BW-1:0] last_rd_exp = '0;
   logic            mptr = 1'b0;
   int              n_rd [2];
   int              n_wr [2];
   int              n_resp [2];
   int              hi_run = 0;
   int              both_hi = 0;

   function automatic logic [BW-1:0] ref_rd(input logic [8:0] a);
      return ref_vld[a] ? ref_mem[a] : init_val(a);
   endfunction

   always @(negedge clk) begin
      logic [1:0]    acc;
      logic          gp, gwe, exp_gp;
      logic [AW-1:0] ga;
      logic [W-1:0]  e;
      int            t;
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         mptr        = 1'b0;
         last_rd_exp = '0;
         hi_run      = 0;
         for (int p = 0; p < 2; p++) begin
            n_rd[p] = 0; n_wr[p] = 0; n_resp[p] = 0;
         end
      end else begin
         if (mem_readable && mem_writable) both_hi++;
         if (mem_readable || mem_writable) begin
            hi_run++;
         end else if (hi_run != 0) begin
            chk("strobe_len", hi_run, MEM_LAT + 1);
            hi_run = 0;
         end
         acc = req_valid & req_ready;
         if (acc != 2'b00) begin
            chk("ready_onehot", $countones(req_ready), 1);
            gp     = acc[1];
            exp_gp = (req_valid == 2'b11) ? mptr : req_valid[1];
            chk("grant_port", gp, exp_gp);
            gwe = req_we[gp];
            ga  = req_addr[gp*AW +: AW];
            if (gwe) begin
               ref_mem[ga[8:0]] = req_wdata[gp*BW +: BW];
               ref_vld[ga[8:0]] = 1'b1;
            end else begin
               last_rd_exp = {ref_rd(ga[8:0]), ref_rd(ga[8:0] + 9'd1)};
            end
            exp_q.push_back({gp, gwe, last_rd_exp});
            acc_q.push_back(cyc_n);
         end
         if (resp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", resp_valid, 2'b00);
            end else begin
               e = exp_q.pop_front();
               t = acc_q.pop_front();
               chk("resp_port", resp_valid, e[W-1] ? 2'b10 : 2'b01);
               chk("resp_data", resp_data, e[2*BW-1:0]);
               chk("latency", cyc_n - t, MEM_LAT + 2);
               n_resp[e[W-1]]++;
               if (e[W-2]) n_wr[e[W-1]]++;
               else        n_rd[e[W-1]]++;
               mptr = ~e[W-1];
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic look();
      @(negedge clk); #1;
   endtask

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic drive(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [BW-1:0] d);
      int   n;
      logic got;
      n   = 0;
      got = 1'b0;
      req_we[p]             = we;
      req_addr[p*AW +: AW]  = a;
      req_wdata[p*BW +: BW] = d;
      req_valid[p]          = 1'b1;
      while (!got && n < 300) begin
         look();
         if (req_ready[p]) got = 1'b1;
         else begin
            n++;
            cyc();
         end
      end
      chk("accept_timeout", got, 1'b1);
      cyc();
      req_valid[p] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         look();
         n++;
      end while (!(exp_q.size() == 0 && dbg_state == ARB_IDLE) && n < 300);
      chk("idle_timeout", exp_q.size(), 0);
      cyc();
   endtask

   task automatic wait_hold();
      int n;
      n = 0;
      do begin
         look();
         n++;
      end while (dbg_state != ARB_HOLD && n < 20);
      chk("reach_hold", dbg_state, ARB_HOLD);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          s0, s1, n;
      logic [1:0]  seen;
      rst       = 1'b1;
      halt      = 1'b0;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (2) cyc();

      // Reset state
      look();
      chk("rst_state", dbg_state, ARB_IDLE);
      chk("rst_strobes", {mem_readable, mem_writable, mem_flush, halt_done}, 4'b0);
      chk("rst_resp", {req_ready, resp_valid}, 4'b0);
      chk("rst_resp_data", resp_data, '0);
      chk("rst_mem_addr", mem_addr, '0);
      cyc();
      rst = 1'b0;
      cyc();

      // Single read on port 0
      drive(0, 1'b0, 16'h0100, '0);
      wait_idle();

      // Write port 1, then read it back on port 0
      drive(1, 1'b1, 16'h0080, 32'hA5A5A5A5);
      drive(0, 1'b0, 16'h0080, '0);
      wait_idle();
      look();
      chk("wr_rd_out1", resp_data[2*BW-1:BW], 32'hA5A5A5A5);
      cyc();

      // Both ports contending: 4 reads each
      s0 = n_resp[0];
      s1 = n_resp[1];
      fork
         begin
            for (int i = 0; i < 4; i++) drive(0, 1'b0, 16'h0010 + 16'(i*2), '0);
         end
         begin
            for (int j = 0; j < 4; j++) drive(1, 1'b0, 16'h0030 + 16'(j*3), '0);
         end
      join
      wait_idle();
      chk("contend_p0_count", n_resp[0] - s0, 4);
      chk("contend_p1_count", n_resp[1] - s1, 4);

      // Reset during HOLD of a write
      drive(1, 1'b1, 16'h0040, 32'h12345678);
      wait_hold();
      rst = 1'b1;
      cyc();
      look();
      chk("mid_rst_state", dbg_state, ARB_IDLE);
      chk("mid_rst_strobes", {mem_readable, mem_writable, mem_flush, halt_done}, 4'b0);
      chk("mid_rst_resp", {req_ready, resp_valid}, 4'b0);
      chk("mid_rst_addr", mem_addr, '0);
      chk("mid_rst_wdata", mem_write, '0);
      chk("mid_rst_resp_data", resp_data, '0);
      cyc();
      rst  = 1'b0;
      seen = '0;
      repeat (5) begin
         look();
         seen = seen | resp_valid;
      end
      chk("no_resp_after_rst", seen, 2'b00);
      cyc();
      fork
         drive(0, 1'b0, 16'h0020, '0);
         drive(1, 1'b0, 16'h0022, '0);
      join
      wait_idle();

`ifdef DATAMEM_ARB_STATS_EN
      // Per-port statistics
      for (int k = 0; k < 3; k++) drive(1, 1'b0, 16'h0060 + 16'(k), '0);
      drive(1, 1'b1, 16'h0070, 32'hCAFE0001);
      drive(1, 1'b1, 16'h0071, 32'hCAFE0002);
      wait_idle();
      look();
      chk("stat_rd1", stat_rd[63:32], n_rd[1]);
      chk("stat_wr1", stat_wr[63:32], n_wr[1]);
      chk("stat_rd0", stat_rd[31:0], n_rd[0]);
      chk("stat_wr0", stat_wr[31:0], n_wr[0]);
      cyc();
`endif

      // Halt while a port 1 read is in HOLD
      drive(1, 1'b0, 16'h0100, '0);
      wait_hold();
      halt = 1'b1;
      n    = 0;
      do begin
         look();
         n++;
      end while (resp_valid == 2'b00 && n < 20);
      chk("halt_resp", resp_valid, 2'b10);
      look();
      chk("flush_state", dbg_state, ARB_FLUSH);
      chk("flush_strobe", mem_flush, 1'b1);
      chk("halt_done", halt_done, 1'b1);
      chk("flush_rw_strobes", {mem_readable, mem_writable}, 2'b00);
      cyc();
      req_valid = 2'b11;
      seen      = '0;
      repeat (6) begin
         look();
         seen = seen | req_ready;
      end
      chk("flush_no_ready", seen, 2'b00);
      chk("halt_done_sticky", halt_done, 1'b1);
      cyc();
      req_valid = 2'b00;

      chk("both_strobes_high", both_hi, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
